jtframe_gain_fader: RTL and testbench
=====================================

# jtframe_gain_fader

Gain controller that sits in front of the four-channel mixer and drives its four 4.4 fixed-point gain inputs. Software or core logic writes per-channel target gains. The fader slews each live gain toward its target by one LSB per fade tick, so level changes, mutes and power-up are click-free. Fade ticks are derived by dividing the audio sample enable, so the ramp rate is programmable and tied to the mixer's sampling.

## Interface
- `DIVW`, default 8: width of the fade-rate divider.
- `RST_TGT`, default 8'h10: target gain loaded at reset for all channels (unity, 1.0 in 4.4).

Ports (clock and reset first):
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `clk` in 1: single clock for the block.
- `cen` in 1: audio sample enable, the same strobe that drives the mixer's `cen`.
- `wr` in 1: target write strobe, one cycle per write.
- `addr` in 2: channel selected by `wr` (0..3).
- `din` in 8: new target gain in 4.4 format.
- `step_div` in DIVW: number of extra `cen` pulses between fade ticks; 0 means a tick on every `cen`.
- `mute` in 1: level-sensitive; while high, the effective target of every channel is 0.
- `gain0`..`gain3` out 8 each: live gains feeding the mixer.
- `busy` out 1: high while any live gain differs from its effective target.
- `done` out 1: one-cycle pulse when `busy` falls.

## Operation
- State:
  - `tgt[0..3]`, 8 bits each.
  - `cur[0..3]`, 8 bits each; these drive `gainN` directly.
  - Divider counter `cnt`, DIVW bits.
  - `busy_l`, a one-bit delayed copy of `busy`.
- Reset (`rst_n` low, any time, including mid-ramp):
  - `tgt` = RST_TGT; `cur` = 0, so `gainN` = 0.
  - `cnt` = 0; `busy_l` = 0; `done` = 0.
  - After release the block fades in from 0 to RST_TGT.
- Effective target per channel: `eff[n]` = `mute` ? 0 : `tgt[n]`.
- Write: on a `clk` edge with `wr`=1, `tgt[addr]` <= `din`.
  - Writes do not depend on `cen`.
  - Writes never touch `cur` directly.
- Divider and tick generation, evaluated only on edges with `cen`=1:
  - If `cnt` >= `step_div`: `cnt` <= 0 and `tick` = 1.
  - Otherwise: `cnt` <= `cnt`+1.
  - The >= compare makes a `step_div` reduced below `cnt` tick on the next `cen`; no wrap stall.
- Fade step, on `tick`, for each channel independently:
  - `cur` < `eff`: `cur` <= `cur`+1.
  - `cur` > `eff`: `cur` <= `cur`-1.
  - Equal: hold.
  - `cur` never overshoots and never wraps: 8'hFF is reached only when the target is 8'hFF, and 0 only when the target is 0.
- Same-edge collision of `wr` and `tick`:
  - The tick compares against the pre-write `tgt` (registered value).
  - The written target takes effect from the next tick.
- `mute` toggling: the ramp reverses direction from the current `cur` on the next tick. There is no jump.
- `busy` = OR over n of (`cur[n]` != `eff[n]`). It is combinational from registers and `mute`.
- `done`: `busy_l` <= `busy` every clock; `done` <= `busy_l` & ~`busy`, so exactly one cycle wide.

## Timing
- Write to target register: 1 clock.
- Write to first gain change:
  - Earliest: the first tick strictly after the write edge.
  - Latest: (`step_div`+1) `cen` pulses after the write edge.
- Ramp duration for a change of D LSBs: D ticks, which is D×(`step_div`+1) `cen` pulses (±1 tick of phase).
- `gainN` changes only on tick edges, so they stay stable between `cen` pulses as the mixer requires.
- `done` asserts 1 clock after the final step, i.e. one clock after `busy` falls.
- `mute` asserted on the same edge as a tick is sampled on that edge: that tick already steps toward 0.

## Test plan
- Reset fade-in, `step_div`=0, `cen` every 4 clocks:
  - `gain0..3` step 0,1,2,…,0x10, one step per `cen`.
  - `busy` is high after reset release and low after 16 `cen` pulses.
  - `done` pulses exactly once, one clock after `busy` falls.
- Divider, `step_div`=3, write `tgt[2]`=0x14 from 0x10:
  - `gain2` takes four ticks, each 4 `cen` apart.
  - `gain2` ends at 0x14 after 16 `cen` ±4; other channels stay at 0x10.
- Mute mid-ramp:
  - Ramp `gain1` 0x10→0x40, then assert `mute` at 0x25.
  - `gain1` descends 0x24,…,0 with no jump.
  - Deassert `mute`: `gain1` climbs back to 0x40.
- Collision: `wr` to ch3 with `din`=0x00 on the same edge as a tick while `tgt[3]`=0x20 and `gain3`=0x10.
  - That tick gives `gain3`=0x11.
  - Subsequent ticks descend to 0.
- Boundaries:
  - `tgt`=0xFF ramps to 0xFF and holds with no wrap.
  - `tgt`=0 from 1 reaches 0 and holds.
  - Lower `step_div` from 200 to 2 while `cnt`=150: tick on the next `cen`.
- Asynchronous reset mid-ramp:
  - Drop `rst_n` between clock edges.
  - All `gainN`=0, `busy_l`=0 and `done`=0 immediately, without waiting for a clock.
  - After release, the fade-in repeats.

Source files
------------

// File: rtl/jtframe_gain_fader.sv
// Four-channel gain slewer for the mixer: each live gain walks one LSB per fade
// tick toward its (optionally muted) target; ticks come from dividing the sample enable.
module jtframe_gain_fader #(
  parameter int         DIVW    = 8,
  parameter logic [7:0] RST_TGT = 8'h10
) (
  input  logic            rst_n,
  input  logic            clk,
  input  logic            cen,
  input  logic            wr,
  input  logic [1:0]      addr,
  input  logic [7:0]      din,
  input  logic [DIVW-1:0] step_div,
  input  logic            mute,
  output logic [7:0]      gain0,
  output logic [7:0]      gain1,
  output logic [7:0]      gain2,
  output logic [7:0]      gain3,
  output logic            busy,
  output logic            done
);

  logic [7:0]      tgt_q [4];
  logic [7:0]      tgt_d [4];
  logic [7:0]      cur_q [4];
  logic [7:0]      cur_d [4];
  logic [7:0]      eff   [4];
  logic [3:0]      diff;
  logic [DIVW-1:0] cnt_q, cnt_d;
  logic            busy_l_q, busy_l_d;
  logic            done_q, done_d;
  logic            tick;

  // The >= compare lets a step_div lowered below cnt fire on the next cen.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (cen) begin
      if (cnt_q >= step_div) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + DIVW'(1);
      end
    end
  end

  // Steps compare against the registered target, so a write on a tick edge
  // only influences the following tick.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      eff[n]   = mute ? 8'h00 : tgt_q[n];
      diff[n]  = (cur_q[n] != eff[n]);
      tgt_d[n] = tgt_q[n];
      cur_d[n] = cur_q[n];
      if (tick) begin
        if (cur_q[n] < eff[n])      cur_d[n] = cur_q[n] + 8'd1;
        else if (cur_q[n] > eff[n]) cur_d[n] = cur_q[n] - 8'd1;
      end
    end
    if (wr) tgt_d[addr] = din;
  end

  assign busy     = |diff;
  assign busy_l_d = busy;
  assign done_d   = busy_l_q & ~busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the small target file is reset (unlike a RAM) because RST_TGT defines the power-up fade-in.
      for (int n = 0; n < 4; n++) begin
        tgt_q[n] <= RST_TGT;
        cur_q[n] <= 8'h00;
      end
      cnt_q    <= '0;
      busy_l_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      for (int n = 0; n < 4; n++) begin
        tgt_q[n] <= tgt_d[n];
        cur_q[n] <= cur_d[n];
      end
      cnt_q    <= cnt_d;
      busy_l_q <= busy_l_d;
      done_q   <= done_d;
    end
  end

  assign gain0 = cur_q[0];
  assign gain1 = cur_q[1];
  assign gain2 = cur_q[2];
  assign gain3 = cur_q[3];
  assign done  = done_q;

endmodule

// File: tb/tb_jtframe_gain_fader.sv
// Bench for jtframe_gain_fader: directed scenarios plus random traffic, all
// checked against an integer model of targets, live gains and the tick divider.
module tb_jtframe_gain_fader;
  localparam int DIVW = 8;

  logic            rst_n = 1'b0;
  logic            clk = 1'b0;
  logic            cen = 1'b0;
  logic            wr = 1'b0;
  logic [1:0]      addr = 2'd0;
  logic [7:0]      din = 8'h00;
  logic [DIVW-1:0] step_div = '0;
  logic            mute = 1'b0;
  logic [7:0]      gain0, gain1, gain2, gain3;
  logic            busy, done;
  logic [33:0]     dut_vec;

  int total = 0;
  int bad   = 0;

  jtframe_gain_fader #(.DIVW(DIVW), .RST_TGT(8'h10)) dut (
    .rst_n(rst_n), .clk(clk), .cen(cen), .wr(wr), .addr(addr), .din(din),
    .step_div(step_div), .mute(mute), .gain0(gain0), .gain1(gain1),
    .gain2(gain2), .gain3(gain3), .busy(busy), .done(done)
  );

  assign dut_vec = {gain3, gain2, gain1, gain0, busy, done};

  always #5 clk = ~clk;

  // Reference model
  int m_tgt[4];
  int m_cur[4];
  int m_cnt;
  bit m_busy_l, m_done;

  function automatic int m_eff(int n);
    return mute ? 0 : m_tgt[n];
  endfunction

  function automatic bit m_busy();
    bit b = 1'b0;
    for (int n = 0; n < 4; n++) if (m_cur[n] != m_eff(n)) b = 1'b1;
    return b;
  endfunction

  function automatic logic [33:0] exp_vec();
    return {8'(m_cur[3]), 8'(m_cur[2]), 8'(m_cur[1]), 8'(m_cur[0]), m_busy(), m_done};
  endfunction

  function automatic void model_reset();
    for (int n = 0; n < 4; n++) begin
      m_tgt[n] = 16;
      m_cur[n] = 0;
    end
    m_cnt = 0; m_busy_l = 1'b0; m_done = 1'b0;
  endfunction

  function automatic void model_edge();
    bit b = m_busy();
    bit t = 1'b0;
    if (cen) begin
      if (m_cnt >= int'(step_div)) begin m_cnt = 0; t = 1'b1; end
      else m_cnt = m_cnt + 1;
    end
    if (t) for (int n = 0; n < 4; n++) begin
      if (m_cur[n] < m_eff(n)) m_cur[n] = m_cur[n] + 1;
      else if (m_cur[n] > m_eff(n)) m_cur[n] = m_cur[n] - 1;
    end
    if (wr) m_tgt[addr] = int'(din);
    m_done   = m_busy_l && !b;
    m_busy_l = b;
  endfunction

  task automatic clk_step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_cen(int idle);
    cen = 1'b1;
    clk_step();
    cen = 1'b0;
    repeat (idle) clk_step();
  endtask

  task automatic write_tgt(logic [1:0] a, logic [7:0] d);
    wr = 1'b1; addr = a; din = d;
    clk_step();
    wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cen = 1'b0; wr = 1'b0; mute = 1'b0; step_div = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #3;
    total++;
    if (dut_vec !== exp_vec()) begin
      bad++; $display("FAIL reset_state: got %h want %h", dut_vec, exp_vec());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fade_in();
    int done_cnt = 0;
    int exp_g;
    step_div = '0;
    for (int p = 0; p < 20; p++) begin
      for (int c = 0; c < 4; c++) begin
        cen = (c == 0);
        clk_step();
        total++;
        if (dut_vec !== exp_vec()) begin
          bad++; $display("FAIL fade_in_cycle: got %h want %h", dut_vec, exp_vec());
        end
        if (done === 1'b1) done_cnt++;
      end
      exp_g = (p + 1 > 16) ? 16 : p + 1;
      total++;
      if (gain0 !== 8'(exp_g)) begin
        bad++; $display("FAIL fade_in_step: got %h want %h", gain0, 8'(exp_g));
      end
    end
    cen = 1'b0;
    total++;
    if (done_cnt != 1) begin
      bad++; $display("FAIL fade_in_done_count: got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_divider();
    step_div = 8'd3;
    write_tgt(2'd2, 8'h14);
    total++;
    if (dut_vec !== exp_vec()) begin
      bad++; $display("FAIL divider_write: got %h want %h", dut_vec, exp_vec());
    end
    for (int p = 0; p < 24; p++) begin
      pulse_cen(1);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL divider_cen: got %h want %h", dut_vec, exp_vec());
      end
    end
    total++;
    if (gain2 !== 8'h14 || gain0 !== 8'h10 || gain1 !== 8'h10 || gain3 !== 8'h10) begin
      bad++; $display("FAIL divider_final: got %h want 10101410", {gain0, gain1, gain2, gain3});
    end
  endtask

  task automatic test_mute();
    int guard = 0;
    logic [7:0] prev;
    step_div = '0;
    write_tgt(2'd1, 8'h40);
    while (gain1 !== 8'h25 && guard < 100) begin
      pulse_cen(1);
      guard++;
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL mute_rise: got %h want %h", dut_vec, exp_vec());
      end
    end
    total++;
    if (gain1 !== 8'h25) begin
      bad++; $display("FAIL mute_reach_25: got %h want 25", gain1);
    end
    mute = 1'b1;
    prev = 8'h25;
    for (int p = 0; p < 8'h30; p++) begin
      pulse_cen(1);
      prev = (prev == 8'h00) ? 8'h00 : prev - 8'd1;
      total++;
      if (gain1 !== prev || dut_vec !== exp_vec()) begin
        bad++; $display("FAIL mute_descend: got %h want %h (gain1 %h want %h)", dut_vec, exp_vec(), gain1, prev);
      end
    end
    mute = 1'b0;
    for (int p = 0; p < 8'h48; p++) begin
      pulse_cen(1);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL mute_release: got %h want %h", dut_vec, exp_vec());
      end
    end
    total++;
    if (gain1 !== 8'h40) begin
      bad++; $display("FAIL mute_final: got %h want 40", gain1);
    end
  endtask

  task automatic test_collision();
    step_div = '0;
    write_tgt(2'd3, 8'h20);
    total++;
    if (gain3 !== 8'h10) begin
      bad++; $display("FAIL collision_pre: got %h want 10", gain3);
    end
    cen = 1'b1; wr = 1'b1; addr = 2'd3; din = 8'h00;
    clk_step();
    cen = 1'b0; wr = 1'b0;
    total++;
    if (gain3 !== 8'h11 || dut_vec !== exp_vec()) begin
      bad++; $display("FAIL collision_tick: got %h want %h (gain3 %h want 11)", dut_vec, exp_vec(), gain3);
    end
    for (int p = 0; p < 8'h14; p++) begin
      pulse_cen(1);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL collision_descend: got %h want %h", dut_vec, exp_vec());
      end
    end
    total++;
    if (gain3 !== 8'h00) begin
      bad++; $display("FAIL collision_final: got %h want 00", gain3);
    end
  endtask

  task automatic test_boundaries();
    int guard = 0;
    logic [7:0] g_before;
    step_div = '0;
    write_tgt(2'd0, 8'hFF);
    for (int i = 0; i < 8'hF8; i++) begin
      pulse_cen(0);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL bound_up: got %h want %h", dut_vec, exp_vec());
      end
    end
    total++;
    if (gain0 !== 8'hFF) begin
      bad++; $display("FAIL bound_ff_hold: got %h want ff", gain0);
    end
    write_tgt(2'd0, 8'h01);
    for (int i = 0; i < 256; i++) begin
      pulse_cen(0);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL bound_down: got %h want %h", dut_vec, exp_vec());
      end
    end
    write_tgt(2'd0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      pulse_cen(0);
      total++;
      if (gain0 !== 8'h00 || dut_vec !== exp_vec()) begin
        bad++; $display("FAIL bound_zero_hold: got %h want %h", dut_vec, exp_vec());
      end
    end
    write_tgt(2'd0, 8'h05);
    step_div = 8'd200;
    while (m_cnt != 150 && guard < 500) begin
      pulse_cen(0);
      guard++;
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL bound_div_count: got %h want %h", dut_vec, exp_vec());
      end
    end
    g_before = gain0;
    step_div = 8'd2;
    pulse_cen(0);
    total++;
    if (gain0 !== g_before + 8'd1 || dut_vec !== exp_vec()) begin
      bad++; $display("FAIL bound_div_lower: got %h want %h", gain0, g_before + 8'd1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      cen  = 1'($urandom_range(0, 1));
      wr   = ($urandom_range(0, 7) == 0);
      addr = 2'($urandom_range(0, 3));
      din  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 63) == 0) mute = ~mute;
      if ($urandom_range(0, 99) == 0) step_div = DIVW'($urandom_range(0, 3));
      clk_step();
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL random_cycle %0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    cen = 1'b0; wr = 1'b0; mute = 1'b0;
  endtask

  task automatic test_async_reset();
    step_div = '0;
    for (int n = 0; n < 4; n++) write_tgt(2'(n), 8'h30);
    repeat (5) pulse_cen(1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (dut_vec !== exp_vec() || dut.busy_l_q !== 1'b0) begin
      bad++; $display("FAIL async_reset: got %h busy_l %b want %h busy_l 0", dut_vec, dut.busy_l_q, exp_vec());
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int p = 0; p < 20; p++) begin
      pulse_cen(0);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL async_refade: got %h want %h", dut_vec, exp_vec());
      end
    end
    total++;
    if ({gain0, gain1, gain2, gain3} !== 32'h10101010) begin
      bad++; $display("FAIL async_refade_final: got %h want 10101010", {gain0, gain1, gain2, gain3});
    end
  endtask

  initial begin
    test_reset();
    test_fade_in();
    test_divider();
    test_mute();
    test_collision();
    test_boundaries();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
